// File: rtl/amba_ahb_master.sv
// ---------------------------------------------------------------------------
// AmbaAhbMaster : AHB-Lite bus initiator
//
// Turns a command (start address, direction, size, beat count) into a
// NONSEQ/SEQ burst with the usual pipelined address and data phases. It pulls
// one write word per beat from the command side and returns read beats as
// single-cycle pulses. It honours slave wait states and the two-cycle ERROR
// response. On an ERROR response the rest of the burst is cancelled.
//
// Ports
//   hclk, hresetn       bus clock, asynchronous active-low reset
//   haddr .. hwdata     AHB-Lite master outputs (hprot is constant)
//   hrdata/hready/hresp AHB-Lite slave responses
//   cmd_*               command handshake; accepted on cmd_valid & cmd_ready
//   wr_ready/wr_data    wr_data is sampled into hwdata when wr_ready is high
//   rd_valid/rd_data    one pulse per read beat, rd_data registered
//   done/err            end of command pulse; err flags an aborted burst
// ---------------------------------------------------------------------------
module amba_ahb_master #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int RW = 2,
    parameter int LW = 5
) (
    input  logic          hclk,
    input  logic          hresetn,
    output logic [AW-1:0] haddr,
    output logic [1:0]    htrans,
    output logic          hwrite,
    output logic [2:0]    hsize,
    output logic [2:0]    hburst,
    output logic [3:0]    hprot,
    output logic [DW-1:0] hwdata,
    input  logic [DW-1:0] hrdata,
    input  logic          hready,
    input  logic [RW-1:0] hresp,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr,
    input  logic          cmd_write,
    input  logic [2:0]    cmd_size,
    input  logic [LW-1:0] cmd_len,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          done,
    output logic          err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADDR  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    localparam logic [2:0] HB_SINGLE = 3'b000;
    localparam logic [2:0] HB_INCR   = 3'b001;

    localparam logic [RW-1:0] RESP_OKAY  = RW'(0);
    localparam logic [RW-1:0] RESP_ERROR = RW'(1);

    logic [1:0]    r_state;
    logic [AW-1:0] r_haddr;
    logic [1:0]    r_htrans;
    logic          r_hwrite;
    logic [2:0]    r_hsize;
    logic [2:0]    r_hburst;
    logic [DW-1:0] r_hwdata;
    logic [LW-1:0] r_remain;
    logic          r_dphase;
    logic          r_rd_valid;
    logic [DW-1:0] r_rd_data;
    logic          r_done;
    logic          r_err;

    logic [AW-1:0] w_lowmask;
    logic [AW-1:0] w_next_addr;
    logic [LW-1:0] w_len;
    logic          w_err_first;
    logic          w_addr_acc;

    // Start address is aligned to the transfer size; a zero length is one beat.
    assign w_lowmask   = (AW'(1) << cmd_size) - AW'(1);
    assign w_len       = (cmd_len == '0) ? LW'(1) : cmd_len;
    assign w_next_addr = r_haddr + (AW'(1) << r_hsize);

    // r_dphase is only set in ADDR/DRAIN/ERR, so this flags the first ERROR cycle.
    assign w_err_first = r_dphase && !hready && (hresp == RESP_ERROR);
    // In ADDR htrans is always NONSEQ or SEQ, so hready alone accepts the phase.
    assign w_addr_acc  = (r_state == S_ADDR) && hready;

    assign haddr     = r_haddr;
    assign htrans    = r_htrans;
    assign hwrite    = r_hwrite;
    assign hsize     = r_hsize;
    assign hburst    = r_hburst;
    assign hprot     = 4'b0011;
    assign hwdata    = r_hwdata;
    assign cmd_ready = (r_state == S_IDLE);
    assign wr_ready  = w_addr_acc && r_hwrite;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign done      = r_done;
    assign err       = r_err;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state    <= S_IDLE;
            r_haddr    <= '0;
            r_htrans   <= HT_IDLE;
            r_hwrite   <= 1'b0;
            r_hsize    <= 3'd0;
            r_hburst   <= HB_SINGLE;
            r_hwdata   <= '0;
            r_remain   <= '0;
            r_dphase   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_haddr  <= cmd_addr & ~w_lowmask;
                        r_htrans <= HT_NONSEQ;
                        r_hwrite <= cmd_write;
                        r_hsize  <= cmd_size;
                        r_hburst <= (w_len == LW'(1)) ? HB_SINGLE : HB_INCR;
                        r_remain <= w_len;
                        r_dphase <= 1'b0;
                        r_state  <= S_ADDR;
                    end
                end
                S_ADDR, S_DRAIN: begin
                    if (w_err_first) begin
                        // Cancel the pending address phase and wait out the ERROR.
                        r_htrans <= HT_IDLE;
                        r_state  <= S_ERR;
                    end else if (hready) begin
                        if (r_dphase && !r_hwrite && (hresp == RESP_OKAY)) begin
                            r_rd_data  <= hrdata;
                            r_rd_valid <= 1'b1;
                        end
                        if (r_state == S_ADDR) begin
                            if (r_hwrite) begin
                                r_hwdata <= wr_data;
                            end
                            r_dphase <= 1'b1;
                            if (r_remain > LW'(1)) begin
                                r_haddr  <= w_next_addr;
                                // Crossing a 1KB boundary restarts the burst.
                                r_htrans <= (w_next_addr[9:0] == 10'd0) ? HT_NONSEQ : HT_SEQ;
                                r_remain <= r_remain - LW'(1);
                            end else begin
                                r_htrans <= HT_IDLE;
                                r_state  <= S_DRAIN;
                            end
                        end else begin
                            r_dphase <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= S_IDLE;
                        end
                    end
                end
                default: begin
                    if (hready) begin
                        r_dphase <= 1'b0;
                        r_done   <= 1'b1;
                        r_err    <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_amba_ahb_master.sv
// ---------------------------------------------------------------------------
// tb_amba_ahb_master : self-checking bench for amba_ahb_master
//
// A behavioural AHB-Lite slave with memory, wait states and error injection
// runs on the falling clock edge. It records every accepted address phase,
// read beat and completion into queues. Each test task pushes its expected
// results onto scoreboard queues and compares them against the observed ones.
// ---------------------------------------------------------------------------
module tb_amba_ahb_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RW = 2;
    localparam int LW = 5;

    logic          hclk = 1'b0;
    logic          hresetn = 1'b0;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic [3:0]    hprot;
    logic [DW-1:0] hwdata;
    logic [DW-1:0] hrdata;
    logic          hready;
    logic [RW-1:0] hresp;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic          cmd_write = 1'b0;
    logic [2:0]    cmd_size = 3'd0;
    logic [LW-1:0] cmd_len = '0;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          done;
    logic          err;

    amba_ahb_master #(.AW(AW), .DW(DW), .RW(RW), .LW(LW)) dut (
        .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_len(cmd_len),
        .wr_ready(wr_ready), .wr_data(wr_data), .rd_valid(rd_valid),
        .rd_data(rd_data), .done(done), .err(err)
    );

    always #5 hclk = ~hclk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] mem [0:1023];

    int cfg_waits = 0;
    int cfg_err_beat = -1;
    int beat_cnt = 0;

    bit          dp_valid = 1'b0;
    logic [31:0] dp_addr;
    bit          dp_write;
    int          dp_waits;
    bit          dp_err;
    int          dp_stage;

    logic [36:0] act_ph[$];
    logic [36:0] exp_ph[$];
    int          act_acc_cyc[$];
    logic [31:0] act_rd[$];
    logic [31:0] exp_rd[$];
    bit          act_err[$];
    int          act_done_cyc[$];
    logic [31:0] wdata[$];
    int          wr_idx = 0;
    int          wr_pulses = 0;
    int          last_dp_cyc = 0;
    int          hold_viol = 0;
    logic [1:0]  err_htrans = 2'b11;

    logic          prev_hready = 1'b1;
    logic [RW-1:0] prev_hresp = '0;
    logic [31:0]   prev_haddr = '0;
    logic [1:0]    prev_htrans = 2'b00;
    logic [31:0]   prev_hwdata = '0;

    // Slave model and monitor: decides this cycle's response on the falling edge.
    initial begin
        hready = 1'b1; hresp = '0; hrdata = '0; wr_data = '0;
        forever begin
            @(negedge hclk);
            cyc++;
            if (!hresetn) begin
                dp_valid = 1'b0; hready = 1'b1; hresp = '0; prev_hready = 1'b1;
            end else begin
                if (!prev_hready && prev_hresp == '0 && prev_htrans[1])
                    if (haddr !== prev_haddr || htrans !== prev_htrans) hold_viol++;
                if (!prev_hready && dp_valid && dp_write && hwdata !== prev_hwdata) hold_viol++;
                if (rd_valid) act_rd.push_back(rd_data);
                if (done) begin act_err.push_back(err); act_done_cyc.push_back(cyc); end
                hresp = '0;
                if (!dp_valid) hready = 1'b1;
                else if (dp_waits > 0) begin hready = 1'b0; dp_waits--; end
                else if (dp_err) begin
                    if (dp_stage == 0) begin hready = 1'b0; hresp = RW'(1); dp_stage = 1; end
                    else begin hready = 1'b1; hresp = RW'(1); err_htrans = htrans; end
                end else begin
                    hready = 1'b1;
                    if (dp_write) mem[dp_addr[11:2]] = hwdata;
                    else hrdata = mem[dp_addr[11:2]];
                    last_dp_cyc = cyc;
                end
                if (hready) begin
                    dp_valid = 1'b0;
                    if (htrans[1]) begin
                        act_ph.push_back({haddr, htrans, hburst});
                        act_acc_cyc.push_back(cyc);
                        dp_valid = 1'b1; dp_addr = haddr; dp_write = hwrite;
                        dp_waits = cfg_waits; dp_err = (beat_cnt == cfg_err_beat);
                        dp_stage = 0; beat_cnt++;
                    end
                end
                wr_data = (wr_idx < wdata.size()) ? wdata[wr_idx] : 32'hDEAD_BEEF;
                prev_hready = hready; prev_hresp = hresp; prev_haddr = haddr;
                prev_htrans = htrans; prev_hwdata = hwdata;
                #1;
                if (wr_ready) begin wr_pulses++; wr_idx++; end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(negedge hclk);
        #2;
    endtask

    task automatic clear_obs();
        act_ph.delete(); exp_ph.delete(); act_acc_cyc.delete();
        act_rd.delete(); exp_rd.delete(); act_err.delete(); act_done_cyc.delete();
        wr_idx = 0; wr_pulses = 0; hold_viol = 0; beat_cnt = 0; err_htrans = 2'b11;
    endtask

    task automatic issue(input logic [31:0] a, input bit w, input logic [2:0] s, input logic [4:0] l);
        int n = 0;
        while (!cmd_ready && n < 200) begin tick(); n++; end
        cmd_addr = a; cmd_write = w; cmd_size = s; cmd_len = l; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        int n = 0;
        while (act_done_cyc.size() == 0 && n < 300) begin tick(); n++; end
        ok = (act_done_cyc.size() != 0);
    endtask

    task automatic test_reset();
        hresetn = 1'b0;
        repeat (3) tick();
        checks++; if (haddr !== 32'h0) begin errors++; $display("[TB] FAIL rst_haddr got %h want 0", haddr); end
        checks++; if (htrans !== 2'b00) begin errors++; $display("[TB] FAIL rst_htrans got %b want 00", htrans); end
        checks++; if ({hwrite, hsize, hburst} !== 7'd0) begin errors++; $display("[TB] FAIL rst_ctrl got %b want 0", {hwrite, hsize, hburst}); end
        checks++; if (hwdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_hwdata got %h want 0", hwdata); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_cmd_ready got %b want 1", cmd_ready); end
        checks++; if ({wr_ready, rd_valid, done, err} !== 4'b0) begin errors++; $display("[TB] FAIL rst_pulses got %b want 0000", {wr_ready, rd_valid, done, err}); end
        checks++; if (rd_data !== 32'h0) begin errors++; $display("[TB] FAIL rst_rd_data got %h want 0", rd_data); end
        checks++; if (hprot !== 4'b0011) begin errors++; $display("[TB] FAIL rst_hprot got %b want 0011", hprot); end
        hresetn = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_write_burst();
        bit ok;
        logic [36:0] e, a;
        clear_obs(); cfg_waits = 0; cfg_err_beat = -1;
        wdata = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
        for (int i = 0; i < 4; i++) exp_ph.push_back({32'h100 + 32'(4 * i), (i == 0) ? 2'b10 : 2'b11, 3'b001});
        issue(32'h100, 1'b1, 3'd2, 5'd4);
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL wr_done got timeout want done"); end
        checks++; if (act_ph.size() != 4) begin errors++; $display("[TB] FAIL wr_beats got %0d want 4", act_ph.size()); end
        while (exp_ph.size() > 0 && act_ph.size() > 0) begin
            e = exp_ph.pop_front(); a = act_ph.pop_front();
            checks++; if (a !== e) begin errors++; $display("[TB] FAIL wr_phase got %h want %h", a, e); end
        end
        checks++; if (wr_pulses != 4) begin errors++; $display("[TB] FAIL wr_ready_cnt got %0d want 4", wr_pulses); end
        if (ok) begin
            checks++; if (act_done_cyc[0] != last_dp_cyc + 1) begin errors++; $display("[TB] FAIL wr_done_lat got %0d want %0d", act_done_cyc[0], last_dp_cyc + 1); end
            checks++; if (act_err[0] !== 1'b0) begin errors++; $display("[TB] FAIL wr_err got %b want 0", act_err[0]); end
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem[64 + i] !== wdata[i]) begin errors++; $display("[TB] FAIL wr_mem%0d got %h want %h", i, mem[64 + i], wdata[i]); end
        end
    endtask

    task automatic test_read_burst();
        bit ok;
        logic [31:0] e, a;
        clear_obs(); cfg_waits = 0; cfg_err_beat = -1;
        exp_rd = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
        issue(32'h100, 1'b0, 3'd2, 5'd4);
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL rd_done got timeout want done"); end
        checks++; if (act_rd.size() != 4) begin errors++; $display("[TB] FAIL rd_cnt got %0d want 4", act_rd.size()); end
        while (exp_rd.size() > 0 && act_rd.size() > 0) begin
            e = exp_rd.pop_front(); a = act_rd.pop_front();
            checks++; if (a !== e) begin errors++; $display("[TB] FAIL rd_data got %h want %h", a, e); end
        end
        if (ok) begin
            checks++; if (act_err[0] !== 1'b0) begin errors++; $display("[TB] FAIL rd_err got %b want 0", act_err[0]); end
        end
    endtask

    task automatic test_wait_states();
        bit ok;
        logic [36:0] a;
        clear_obs(); cfg_waits = 2; cfg_err_beat = -1;
        mem[0] = 32'hCAFE_0003;
        exp_rd.push_back(32'hCAFE_0003);
        exp_ph.push_back({32'h003, 2'b10, 3'b000});
        issue(32'h003, 1'b0, 3'd0, 5'd1);
        wait_done(ok);
        checks++; if (!ok || act_ph.size() != 1) begin errors++; $display("[TB] FAIL ws_single got %0d phases want 1", act_ph.size()); end
        if (ok && act_ph.size() == 1) begin
            a = act_ph.pop_front();
            checks++; if (a !== exp_ph[0]) begin errors++; $display("[TB] FAIL ws_phase got %h want %h", a, exp_ph[0]); end
            checks++; if (act_done_cyc[0] != act_acc_cyc[0] + 4) begin errors++; $display("[TB] FAIL ws_latency got %0d want %0d", act_done_cyc[0], act_acc_cyc[0] + 4); end
        end
        checks++; if (act_rd.size() != 1 || act_rd[0] !== exp_rd[0]) begin errors++; $display("[TB] FAIL ws_rd got %0d beats want 1 of %h", act_rd.size(), exp_rd[0]); end
        clear_obs(); cfg_waits = 1;
        wdata = '{32'h5A5A_0000, 32'h5A5A_0001, 32'h5A5A_0002};
        issue(32'h300, 1'b1, 3'd2, 5'd3);
        wait_done(ok);
        clear_obs(); cfg_waits = 2;
        exp_rd = '{32'h5A5A_0000, 32'h5A5A_0001, 32'h5A5A_0002};
        issue(32'h300, 1'b0, 3'd2, 5'd3);
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL ws_burst got timeout want done"); end
        checks++; if (act_rd.size() != 3) begin errors++; $display("[TB] FAIL ws_burst_cnt got %0d want 3", act_rd.size()); end
        for (int i = 0; i < 3 && i < act_rd.size(); i++) begin
            checks++; if (act_rd[i] !== exp_rd[i]) begin errors++; $display("[TB] FAIL ws_burst_rd%0d got %h want %h", i, act_rd[i], exp_rd[i]); end
        end
        checks++; if (hold_viol != 0) begin errors++; $display("[TB] FAIL ws_hold got %0d changes want 0", hold_viol); end
        cfg_waits = 0;
    endtask

    task automatic test_error();
        bit ok;
        clear_obs(); cfg_waits = 0; cfg_err_beat = 1;
        for (int i = 0; i < 4; i++) mem[128 + i] = 32'h0BAD_0000 + 32'(i);
        wdata = '{32'h7700_0000, 32'h7700_0001, 32'h7700_0002, 32'h7700_0003};
        issue(32'h200, 1'b1, 3'd2, 5'd4);
        wait_done(ok);
        checks++; if (!ok || act_err[0] !== 1'b1) begin errors++; $display("[TB] FAIL err_wr_flag got ok=%0b want done with err=1", ok); end
        checks++; if (act_ph.size() != 2) begin errors++; $display("[TB] FAIL err_wr_beats got %0d want 2", act_ph.size()); end
        checks++; if (wr_pulses != 2) begin errors++; $display("[TB] FAIL err_wr_ready got %0d want 2", wr_pulses); end
        checks++; if (err_htrans !== 2'b00) begin errors++; $display("[TB] FAIL err_htrans got %b want 00", err_htrans); end
        checks++; if (mem[128] !== 32'h7700_0000 || mem[129] !== 32'h0BAD_0001 || mem[130] !== 32'h0BAD_0002) begin
            errors++; $display("[TB] FAIL err_mem got %h %h %h want 77000000 0bad0001 0bad0002", mem[128], mem[129], mem[130]); end
        clear_obs(); cfg_err_beat = 0;
        issue(32'h100, 1'b0, 3'd2, 5'd2);
        wait_done(ok);
        checks++; if (!ok || act_err[0] !== 1'b1) begin errors++; $display("[TB] FAIL err_rd_flag got ok=%0b want done with err=1", ok); end
        checks++; if (act_rd.size() != 0 || act_ph.size() != 1) begin errors++; $display("[TB] FAIL err_rd_beats got rd=%0d ph=%0d want 0 1", act_rd.size(), act_ph.size()); end
        cfg_err_beat = -1;
    endtask

    task automatic test_boundary();
        bit ok;
        logic [36:0] e, a;
        clear_obs(); cfg_waits = 0; cfg_err_beat = -1;
        wdata = '{32'hB0_0000, 32'hB0_0001, 32'hB0_0002, 32'hB0_0003};
        exp_ph = '{{32'h3F8, 2'b10, 3'b001}, {32'h3FC, 2'b11, 3'b001}, {32'h400, 2'b10, 3'b001}, {32'h404, 2'b11, 3'b001}};
        issue(32'h3F8, 1'b1, 3'd2, 5'd4);
        wait_done(ok);
        checks++; if (!ok || act_ph.size() != 4) begin errors++; $display("[TB] FAIL kb_beats got %0d want 4", act_ph.size()); end
        while (exp_ph.size() > 0 && act_ph.size() > 0) begin
            e = exp_ph.pop_front(); a = act_ph.pop_front();
            checks++; if (a !== e) begin errors++; $display("[TB] FAIL kb_phase got %h want %h", a, e); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_obs(); cfg_waits = 0; cfg_err_beat = -1;
        wdata = '{32'hABCD_1234};
        issue(32'h107, 1'b1, 3'd2, 5'd0);
        wait_done(ok);
        checks++; if (!ok || cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready got %b want 1 with done", cmd_ready); end
        cmd_addr = 32'h100; cmd_write = 1'b0; cmd_size = 3'd2; cmd_len = 5'd1; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        checks++; if (htrans !== 2'b10 || haddr !== 32'h100) begin errors++; $display("[TB] FAIL b2b_nonseq got %b/%h want 10/00000100", htrans, haddr); end
        cfg_waits = 2;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy got %b want 0", cmd_ready); end
        cmd_addr = 32'h300; cmd_write = 1'b1; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        act_done_cyc.delete(); act_err.delete();
        wait_done(ok);
        repeat (4) tick();
        checks++; if (act_ph.size() != 2) begin errors++; $display("[TB] FAIL b2b_phases got %0d want 2", act_ph.size()); end
        if (act_ph.size() > 0) begin
            checks++; if (act_ph[0] !== {32'h104, 2'b10, 3'b000}) begin errors++; $display("[TB] FAIL b2b_align got %h want %h", act_ph[0], {32'h104, 2'b10, 3'b000}); end
        end
        checks++; if (act_rd.size() != 1 || act_rd[0] !== 32'h1111_0001) begin errors++; $display("[TB] FAIL b2b_rd got %0d beats want 1 of 11110001", act_rd.size()); end
        cfg_waits = 0;
    endtask

    task automatic test_reset_midburst();
        int n = 0;
        clear_obs(); cfg_waits = 2; cfg_err_beat = -1;
        issue(32'h100, 1'b0, 3'd2, 5'd4);
        while (act_ph.size() < 2 && n < 100) begin tick(); n++; end
        tick();
        hresetn = 1'b0;
        #1;
        checks++; if (haddr !== 32'h0 || htrans !== 2'b00) begin errors++; $display("[TB] FAIL mid_rst_bus got %h/%b want 0/00", haddr, htrans); end
        checks++; if ({hwrite, hsize, hburst} !== 7'd0 || rd_data !== 32'h0) begin errors++; $display("[TB] FAIL mid_rst_regs got %b/%h want 0/0", {hwrite, hsize, hburst}, rd_data); end
        checks++; if (cmd_ready !== 1'b1 || {wr_ready, rd_valid, done, err} !== 4'b0) begin errors++; $display("[TB] FAIL mid_rst_hs got %b/%b want 1/0000", cmd_ready, {wr_ready, rd_valid, done, err}); end
        repeat (2) tick();
        hresetn = 1'b1;
        repeat (8) tick();
        checks++; if (act_done_cyc.size() != 0) begin errors++; $display("[TB] FAIL mid_rst_done got %0d want 0", act_done_cyc.size()); end
        cfg_waits = 0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | 32'(i);
        $display("[TB] start");
        test_reset();
        test_write_burst();
        test_read_burst();
        test_wait_states();
        test_error();
        test_boundary();
        test_back_to_back();
        test_reset_midburst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
